mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter DWidth, default 32, SHALL set operand and result width.
REQ-002 Parameter Lat, default 2, legal range 1 to 4, SHALL set the handshake-to-response latency in cycles.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be a synchronous, active-high reset.
REQ-005 flush_i  input  1  SHALL be a synchronous kill of all in-flight operations.
REQ-006 req0_valid_i / req1_valid_i  input  1  SHALL each indicate that requester 0 / 1 presents an operation.
REQ-007 req0_ready_o / req1_ready_o  output  1  SHALL each be the grant (accept) for requester 0 / 1.
REQ-008 req0_op_i / req1_op_i  input  2  SHALL each select the operation: 00 MUL (low half, signed x signed), 01 MULH (high, signed x signed), 10 MULHSU (high, signed a x unsigned b), 11 MULHU (high, unsigned x unsigned).
REQ-009 req0_a_i, req0_b_i, req1_a_i, req1_b_i  input  DWidth  SHALL be the operands a and b.
REQ-010 rsp0_valid_o / rsp1_valid_o  output  1  SHALL each be a one-cycle response strobe to the owning requester.
REQ-011 rsp0_data_o / rsp1_data_o  output  DWidth  SHALL each carry the result; valid only while the matching strobe is high.
REQ-012 busy_o  output  1  SHALL be high while any pipeline stage holds a valid operation.

Function
REQ-013 Handshake: an operation SHALL be accepted in a cycle where reqN_valid_i and reqN_ready_o are both 1; at most one acceptance per cycle.
REQ-014 reqN_ready_o SHALL be combinational, and SHALL be 1 only if reqN_valid_i=1, the requester wins arbitration, and flush_i=0 and rst_i=0.
REQ-015 The pipeline SHALL accept one operation every cycle (throughput 1); there is no response backpressure, so ready never depends on response state.
REQ-016 A requester SHALL hold valid, op and operands stable until accepted; the bench flags any retraction or change.
REQ-017 Product SHALL be the full 2*DWidth-bit product, with signedness per REQ-008; MUL returns bits [DWidth-1:0] and the others return bits [2*DWidth-1:DWidth].
REQ-018 The result and requester ID SHALL travel through exactly Lat register stages, so rspN_valid_o pulses exactly Lat cycles after the acceptance edge, only on the accepted requester's port.
REQ-019 Responses SHALL return in acceptance order; both rsp strobes SHALL never be high in the same cycle.
REQ-020 rspN_data_o SHALL be 0 whenever rspN_valid_o=0.
REQ-021 A single requester SHALL win whenever it alone is valid, including back-to-back cycles.
REQ-022 On a cycle with flush_i=1, the block SHALL clear all stage valid bits at the next edge; no response is issued for operations in flight or presented that cycle.
REQ-023 Flush SHALL NOT alter the arbitration pointer.
REQ-024 If an acceptance and a flush occur in the same cycle, flush wins: ready is 0 per REQ-014, so there is no acceptance.
REQ-025 busy_o SHALL be the OR of the stage valid bits, with a registered source.

Reset
REQ-026 While rst_i=1, the block SHALL clear all stage valid bits, IDs and data registers at the clock edge.
REQ-027 While rst_i=1, the block SHALL drive both ready outputs to 0.
REQ-028 Reset values: all rsp*_valid_o=0, rsp*_data_o=0, busy_o=0, and the arbitration pointer set so that requester 0 wins the first contention.
REQ-029 Reset asserted mid-operation SHALL discard in-flight operations, with no response after reset release.

Configuration
REQ-030 Macro MUL_ARB_RR_EN defined: on contention the block SHALL grant round-robin; the grant goes to the requester not granted at the most recent acceptance, and the pointer updates only on acceptance.
REQ-031 Macro MUL_ARB_RR_EN undefined: the block SHALL use fixed priority with requester 0 always winning contention, and SHALL contain no pointer register.

Verification
REQ-032 Reset then req0 MUL a=7 b=-3 (0xFFFFFFFD) -> ready0=1 the same cycle; rsp0_valid_o pulses after Lat=2 cycles with data 0xFFFFFFEB.
REQ-033 req1 MULHU a=b=0xFFFFFFFF -> rsp1_data_o=0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU a=0xFFFFFFFF b=2 -> 0xFFFFFFFF.
REQ-034 Both requesters valid for 4 cycles with RR enabled -> grants 0,1,0,1 and responses on cycles 2..5 alternating ports; with the macro undefined -> grants 0,0,0,0 and ready1 held at 0.
REQ-035 Accept req0 at cycle 0 and req1 at cycle 1, then flush_i=1 at cycle 1 -> req1 not accepted, no responses, busy_o=0 from cycle 2.
REQ-036 Reset asserted one cycle after acceptance -> no rsp strobe ever; ready=0 during reset; the first post-reset contention goes to req0.
REQ-037 Random back-to-back traffic, 1000 operations, Lat=1..4 -> every response matches the reference model, arrives in order and on the correct port, and no two strobes are high in the same cycle.

Source files
------------

// File: rtl/mul_arbiter.sv
// mul_arbiter: two-requester arbiter in front of a fully pipelined multiplier.
// Results travel through Lat register stages together with the requester ID
// and are returned on the port of the requester that issued them.
// Optional feature macro: MUL_ARB_RR_EN (round-robin arbitration on contention);
// when undefined, requester 0 has fixed priority and no pointer register exists.
module mul_arbiter #(
  parameter int DWidth = 32,
  parameter int Lat    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [1:0]        req0_op_i,
  input  logic [DWidth-1:0] req0_a_i,
  input  logic [DWidth-1:0] req0_b_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [1:0]        req1_op_i,
  input  logic [DWidth-1:0] req1_a_i,
  input  logic [DWidth-1:0] req1_b_i,
  output logic              rsp0_valid_o,
  output logic [DWidth-1:0] rsp0_data_o,
  output logic              rsp1_valid_o,
  output logic [DWidth-1:0] rsp1_data_o,
  output logic              busy_o
);

  localparam int PW = 2 * DWidth;

  typedef enum logic [1:0] {
    OpMul    = 2'b00,
    OpMulh   = 2'b01,
    OpMulhsu = 2'b10,
    OpMulhu  = 2'b11
  } op_e;

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              acceptId;
  op_e               selOp;
  logic [DWidth-1:0] selA;
  logic [DWidth-1:0] selB;
  logic              aSigned;
  logic              bSigned;
  logic [PW-1:0]     aExt;
  logic [PW-1:0]     bExt;
  logic [PW-1:0]     product;
  logic [DWidth-1:0] result;

  logic [Lat-1:0]    stValid_q;
  logic [Lat-1:0]    stValid_d;
  logic [Lat-1:0]    stId_q;
  logic [Lat-1:0]    stId_d;
  logic [DWidth-1:0] stData_q [Lat];
  logic [DWidth-1:0] stData_d [Lat];

`ifdef MUL_ARB_RR_EN
  // Pointer names the requester that has priority on the next contention
  logic rrPtr_q;
  logic rrPtr_d;

  // Contention goes to the pointed-at requester; a lone requester always wins
  always_comb begin
    grant0 = req0_valid_i && (!req1_valid_i || !rrPtr_q);
    grant1 = req1_valid_i && (!req0_valid_i || rrPtr_q);
  end

  // Priority passes to the requester that was not granted, only on acceptance
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (accept) begin
      rrPtr_d = !acceptId;
    end
  end

  // Pointer register; reset favours requester 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rrPtr_q <= 1'b0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end
`else
  // Fixed priority: requester 0 always wins contention
  always_comb begin
    grant0 = req0_valid_i;
    grant1 = req1_valid_i && !req0_valid_i;
  end
`endif

  // Flush and reset suppress every grant, so nothing enters while they are high
  assign req0_ready_o = grant0 && !flush_i && !rst_i;
  assign req1_ready_o = grant1 && !flush_i && !rst_i;
  assign accept       = req0_ready_o || req1_ready_o;
  assign acceptId     = req1_ready_o;

  // Select the winning operation and form the full-width product
  always_comb begin
    selOp   = acceptId ? op_e'(req1_op_i) : op_e'(req0_op_i);
    selA    = acceptId ? req1_a_i : req0_a_i;
    selB    = acceptId ? req1_b_i : req0_b_i;
    aSigned = (selOp != OpMulhu);
    bSigned = (selOp == OpMul) || (selOp == OpMulh);
    aExt    = {{DWidth{aSigned & selA[DWidth-1]}}, selA};
    bExt    = {{DWidth{bSigned & selB[DWidth-1]}}, selB};
    product = aExt * bExt;
    result  = (selOp == OpMul) ? product[DWidth-1:0] : product[PW-1:DWidth];
  end

  // Next state of the result pipeline; a flush kills every stage
  always_comb begin
    stValid_d = '0;
    stId_d    = '0;
    for (int i = 0; i < Lat; i++) begin
      stData_d[i] = '0;
    end
    stValid_d[0] = accept;
    stId_d[0]    = acceptId;
    stData_d[0]  = result;
    for (int i = 1; i < Lat; i++) begin
      stValid_d[i] = stValid_q[i-1];
      stId_d[i]    = stId_q[i-1];
      stData_d[i]  = stData_q[i-1];
    end
    if (flush_i) begin
      stValid_d = '0;
    end
  end

  // Pipeline registers, fully cleared by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stValid_q <= '0;
      stId_q    <= '0;
      for (int i = 0; i < Lat; i++) begin
        stData_q[i] <= '0;
      end
    end else begin
      stValid_q <= stValid_d;
      stId_q    <= stId_d;
      for (int i = 0; i < Lat; i++) begin
        stData_q[i] <= stData_d[i];
      end
    end
  end

  // The last stage drives the owning port only; data is zero when idle
  always_comb begin
    rsp0_valid_o = stValid_q[Lat-1] && !stId_q[Lat-1];
    rsp1_valid_o = stValid_q[Lat-1] &&  stId_q[Lat-1];
    rsp0_data_o  = rsp0_valid_o ? stData_q[Lat-1] : '0;
    rsp1_data_o  = rsp1_valid_o ? stData_q[Lat-1] : '0;
    busy_o       = |stValid_q;
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: scoreboard bench for mul_arbiter. Acceptances predicted by
// the bench's own arbitration model push expected results into a queue that is
// drained as responses fall due. Honours MUL_ARB_RR_EN like the design.
module tb_mul_arbiter;

  localparam int DW  = 32;
  localparam int LAT = 2;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          due;
  } sbEntry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          v0;
  logic          v1;
  logic [1:0]    op0;
  logic [1:0]    op1;
  logic [DW-1:0] a0;
  logic [DW-1:0] b0;
  logic [DW-1:0] a1;
  logic [DW-1:0] b1;
  logic          rdy0;
  logic          rdy1;
  logic          rv0;
  logic          rv1;
  logic [DW-1:0] rd0;
  logic [DW-1:0] rd1;
  logic          busy;

  int       checkCount = 0;
  int       failCount  = 0;
  int       cycle      = 0;
  bit       monEn      = 1'b0;
  sbEntry_t sbQ[$];
  sbEntry_t popped;
  sbEntry_t pushed;
  bit       expV0;
  bit       expV1;
  bit       eRdy0;
  bit       eRdy1;
  bit       winner;
  logic [31:0] expD0;
  logic [31:0] expD1;
`ifdef MUL_ARB_RR_EN
  bit       ptrModel = 1'b0;
`endif

  mul_arbiter #(.DWidth(DW), .Lat(LAT)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .req0_valid_i (v0),
    .req0_ready_o (rdy0),
    .req0_op_i    (op0),
    .req0_a_i     (a0),
    .req0_b_i     (b0),
    .req1_valid_i (v1),
    .req1_ready_o (rdy1),
    .req1_op_i    (op1),
    .req1_a_i     (a1),
    .req1_b_i     (b1),
    .rsp0_valid_o (rv0),
    .rsp0_data_o  (rd0),
    .rsp1_valid_o (rv1),
    .rsp1_data_o  (rd1),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  // Reference product from 64-bit two's-complement arithmetic
  function automatic logic [31:0] refMul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ea;
    longint unsigned eb;
    longint unsigned p;
    ea = (op == 2'b11) ? {32'b0, a} : longint'($signed(a));
    eb = (op == 2'b00 || op == 2'b01) ? longint'($signed(b)) : {32'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pickOperand();
    logic [31:0] corner [5];
    corner[0] = 32'h0;
    corner[1] = 32'h1;
    corner[2] = 32'h7FFFFFFF;
    corner[3] = 32'h80000000;
    corner[4] = 32'hFFFFFFFF;
    if ($urandom_range(3) == 0) return corner[$urandom_range(4)];
    return $urandom;
  endfunction

  // Cycle monitor: responses, busy and ready against the scoreboard and arbitration model
  always @(negedge clk) begin
    if (monEn) begin
      expV0 = 1'b0;
      expV1 = 1'b0;
      expD0 = '0;
      expD1 = '0;
      checkOutput("busy", 64'(busy), 64'(sbQ.size() != 0));
      if (sbQ.size() > 0 && sbQ[0].due == cycle) begin
        popped = sbQ.pop_front();
        if (popped.port) begin
          expV1 = 1'b1;
          expD1 = popped.data;
        end else begin
          expV0 = 1'b1;
          expD0 = popped.data;
        end
      end
      checkOutput("rsp0_valid", 64'(rv0), 64'(expV0));
      checkOutput("rsp1_valid", 64'(rv1), 64'(expV1));
      checkOutput("rsp0_data", 64'(rd0), 64'(expD0));
      checkOutput("rsp1_data", 64'(rd1), 64'(expD1));
      checkOutput("rsp_exclusive", 64'(rv0 & rv1), 64'(0));

      if (v0 && v1) begin
`ifdef MUL_ARB_RR_EN
        winner = ptrModel;
`else
        winner = 1'b0;
`endif
      end else begin
        winner = v1;
      end
      eRdy0 = v0 && (winner == 1'b0) && !flush && !rst;
      eRdy1 = v1 && (winner == 1'b1) && !flush && !rst;
      checkOutput("ready0", 64'(rdy0), 64'(eRdy0));
      checkOutput("ready1", 64'(rdy1), 64'(eRdy1));

      if (eRdy0 || eRdy1) begin
        pushed.port = eRdy1;
        pushed.data = eRdy1 ? refMul(op1, a1, b1) : refMul(op0, a0, b0);
        pushed.due  = cycle + LAT;
        sbQ.push_back(pushed);
`ifdef MUL_ARB_RR_EN
        ptrModel = eRdy0;
`endif
      end
      if (flush || rst) sbQ.delete();
`ifdef MUL_ARB_RR_EN
      if (rst) ptrModel = 1'b0;
`endif
    end
  end

  task automatic applyStimulus(input bit iv0, input logic [1:0] iop0, input logic [31:0] ia0, input logic [31:0] ib0,
                               input bit iv1, input logic [1:0] iop1, input logic [31:0] ia1, input logic [31:0] ib1,
                               input bit ifl, input bit irs);
    v0 = iv0; op0 = iop0; a0 = ia0; b0 = ib0;
    v1 = iv1; op1 = iop1; a1 = ia1; b1 = ib1;
    flush = ifl;
    rst   = irs;
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    v0 = 1'b0;
    v1 = 1'b0;
    flush = 1'b0;
    rst = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    setIdle();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait for a strobe on one port, then compare its data
  task automatic expectRsp(input string tag, input bit port, input logic [31:0] expData);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < LAT + 4 && !seen; i++) begin
      @(negedge clk);
      if (port ? rv1 : rv0) begin
        seen = 1'b1;
        checkOutput(tag, 64'(port ? rd1 : rd0), 64'(expData));
      end
      @(posedge clk);
      #1;
    end
    if (!seen) checkOutput({tag, "_seen"}, 64'(seen), 64'(1));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] g0Hist;
    logic [3:0] g1Hist;
    logic [3:0] g0Exp;
    logic [3:0] g1Exp;
    int  accepted;
    int  iter;
    bit  p0;
    bit  p1;
    bit  r0;
    bit  r1;

    rst = 1'b1; flush = 1'b0; v0 = 1'b0; v1 = 1'b0;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    @(posedge clk);
    #1;
    monEn = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    setIdle();
    idleCycles(1);

    $display("[TB] MUL on requester 0");
    applyStimulus(1, 2'b00, 32'd7, 32'hFFFFFFFD, 0, 2'b00, 0, 0, 0, 0);
    setIdle();
    expectRsp("mul_7x-3", 1'b0, 32'hFFFFFFEB);

    $display("[TB] high-half ops on requester 1");
    applyStimulus(0, 2'b00, 0, 0, 1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    setIdle();
    expectRsp("mulhu_ff", 1'b1, 32'hFFFFFFFE);
    applyStimulus(0, 2'b00, 0, 0, 1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    setIdle();
    expectRsp("mulh_ff", 1'b1, 32'h00000000);
    applyStimulus(0, 2'b00, 0, 0, 1, 2'b10, 32'hFFFFFFFF, 32'd2, 0, 0);
    setIdle();
    expectRsp("mulhsu_ff_2", 1'b1, 32'hFFFFFFFF);

    $display("[TB] four cycles of contention");
    v0 = 1'b1; op0 = 2'b00; a0 = 32'd3; b0 = 32'd5;
    v1 = 1'b1; op1 = 2'b11; a1 = 32'h12345678; b1 = 32'h9ABCDEF0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g0Hist[i] = rdy0;
      g1Hist[i] = rdy1;
      @(posedge clk);
      #1;
    end
    setIdle();
`ifdef MUL_ARB_RR_EN
    g0Exp = 4'b0101;
    g1Exp = 4'b1010;
`else
    g0Exp = 4'b1111;
    g1Exp = 4'b0000;
`endif
    checkOutput("contend_grants0", 64'(g0Hist), 64'(g0Exp));
    checkOutput("contend_grants1", 64'(g1Hist), 64'(g1Exp));
    idleCycles(LAT + 2);

    $display("[TB] flush kills in-flight work");
    applyStimulus(1, 2'b00, 32'd9, 32'd9, 0, 2'b00, 0, 0, 0, 0);
    applyStimulus(0, 2'b00, 0, 0, 1, 2'b00, 32'd4, 32'd4, 1, 0);
    setIdle();
    @(negedge clk);
    checkOutput("flush_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    idleCycles(LAT + 2);
    applyStimulus(1, 2'b01, 32'h80000000, 32'd3, 1, 2'b00, 32'd11, 32'd13, 0, 0);
    setIdle();
    idleCycles(LAT + 2);

    $display("[TB] reset in flight");
    applyStimulus(1, 2'b00, 32'd5, 32'd6, 0, 2'b00, 0, 0, 0, 0);
    applyStimulus(1, 2'b00, 32'd5, 32'd6, 1, 2'b00, 32'd1, 32'd2, 0, 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ready0", 64'(rdy0), 64'(1));
    checkOutput("post_reset_ready1", 64'(rdy1), 64'(0));
    @(posedge clk);
    #1;
    idleCycles(LAT + 3);

    $display("[TB] random back-to-back traffic");
    accepted = 0;
    iter = 0;
    p0 = 1'b0;
    p1 = 1'b0;
    while (accepted < 1000 && iter < 20000) begin
      iter++;
      if (!p0 && $urandom_range(3) != 0) begin
        p0 = 1'b1;
        op0 = 2'($urandom_range(3));
        a0 = pickOperand();
        b0 = pickOperand();
      end
      if (!p1 && $urandom_range(3) != 0) begin
        p1 = 1'b1;
        op1 = 2'($urandom_range(3));
        a1 = pickOperand();
        b1 = pickOperand();
      end
      v0 = p0;
      v1 = p1;
      flush = ($urandom_range(40) == 0);
      @(negedge clk);
      r0 = rdy0;
      r1 = rdy1;
      @(posedge clk);
      #1;
      if (r0) begin
        p0 = 1'b0;
        accepted++;
      end
      if (r1) begin
        p1 = 1'b0;
        accepted++;
      end
    end
    idleCycles(LAT + 3);
    checkOutput("random_ops_done", 64'(accepted >= 1000), 64'(1));
    checkOutput("sb_drained", 64'(sbQ.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
